// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: two-entry skid buffer between MEM/WB and the register file write port.
// Ports: in_* upstream entry (valid/ready handshake), flush discards everything held plus the
// current input, out_* entry towards the register file (out_we is the qualified write strobe),
// retire_cnt counts drained writing entries. Defining WB_FWD_EN adds fwd_rs*/fwd_hit*/fwd_data*
// combinational forwarding lookups into the held entries.
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_we,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we,
  output logic [CNT_W-1:0]  retire_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_rs1,
  input  logic [ADDR_W-1:0] fwd_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic              out_we_r, skid_we;
  logic [ADDR_W-1:0] skid_addr;
  logic [DATA_W-1:0] skid_data;
  logic              accept, drain, ld_out, ld_skid, mv_skid;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_we    = out_valid && out_we_r && (out_addr != '0);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  always_comb begin
    state_nx = state;
    ld_out   = 1'b0;
    ld_skid  = 1'b0;
    mv_skid  = 1'b0;
    case (state)
      EMPTY: begin
        state_nx = accept ? ONE : EMPTY;
        ld_out   = accept;
      end
      ONE: begin
        state_nx = (accept && !drain) ? FULL : (!accept && drain) ? EMPTY : ONE;
        ld_out   = accept && drain;
        ld_skid  = accept && !drain;
      end
      FULL: begin
        state_nx = drain ? ONE : FULL;
        mv_skid  = drain;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx = EMPTY;
      ld_out   = 1'b0;
      ld_skid  = 1'b0;
      mv_skid  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      out_addr   <= '0;
      out_data   <= '0;
      out_we_r   <= 1'b0;
      skid_addr  <= '0;
      skid_data  <= '0;
      skid_we    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= state_nx;
      if (ld_out) begin
        out_addr <= in_addr;
        out_data <= in_data;
        out_we_r <= in_we;
      end else if (mv_skid) begin
        out_addr <= skid_addr;
        out_data <= skid_data;
        out_we_r <= skid_we;
      end
      if (ld_skid) begin
        skid_addr <= in_addr;
        skid_data <= in_data;
        skid_we   <= in_we;
      end
      if (drain && out_we)
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`ifdef WB_FWD_EN
  logic s1, o1, s2, o2;
  // SKID holds the younger entry, so it wins over OUT on a double match
  assign s1        = (state == FULL) && skid_we && (skid_addr == fwd_rs1);
  assign o1        = out_valid && out_we_r && (out_addr == fwd_rs1);
  assign s2        = (state == FULL) && skid_we && (skid_addr == fwd_rs2);
  assign o2        = out_valid && out_we_r && (out_addr == fwd_rs2);
  assign fwd_hit1  = (fwd_rs1 != '0) && (s1 || o1);
  assign fwd_hit2  = (fwd_rs2 != '0) && (s2 || o2);
  assign fwd_data1 = s1 ? skid_data : out_data;
  assign fwd_data2 = s2 ? skid_data : out_data;
`endif
endmodule

// File: tb/tb_wb_pipe_reg.sv
// tb_wb_pipe_reg: directed + random scoreboard bench for wb_pipe_reg (CNT_W=4 to reach counter wrap).
module tb_wb_pipe_reg;
  localparam int DW = 32, AW = 5, CW = 4;
  logic          clk = 1'b0, reset = 1'b0;
  logic          in_valid = 1'b0, in_we = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_we;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [CW-1:0] retire_cnt;
`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_rs1 = '0, fwd_rs2 = '0;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
`endif
  wb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_we(in_we), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_we(out_we), .retire_cnt(retire_cnt)
`ifdef WB_FWD_EN
    , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
  } ent_t;
  ent_t          q[$];
  logic [CW-1:0] cnt = '0;
  int            tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic iv, input logic [AW-1:0] ia, input logic [DW-1:0] id,
                      input logic iw, input logic ordy, input logic fl);
    bit acc, drn;
    @(negedge clk);
    in_valid = iv; in_addr = ia; in_data = id; in_we = iw; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("retire_cnt", retire_cnt, cnt);
    if (q.size() > 0) begin
      chk("out_addr", out_addr, q[0].a);
      chk("out_data", out_data, q[0].d);
      chk("out_we", out_we, q[0].w && q[0].a != '0);
    end else
      chk("out_we_idle", out_we, 1'b0);
`ifdef WB_FWD_EN
    begin
      logic h1 = 1'b0, h2 = 1'b0;
      logic [DW-1:0] d1 = '0, d2 = '0;
      foreach (q[i]) begin
        if (q[i].w && q[i].a == fwd_rs1 && fwd_rs1 != '0) begin h1 = 1'b1; d1 = q[i].d; end
        if (q[i].w && q[i].a == fwd_rs2 && fwd_rs2 != '0) begin h2 = 1'b1; d2 = q[i].d; end
      end
      chk("fwd_hit1", fwd_hit1, h1);
      chk("fwd_hit2", fwd_hit2, h2);
      if (h1) chk("fwd_data1", fwd_data1, d1);
      if (h2) chk("fwd_data2", fwd_data2, d2);
    end
`endif
    acc = iv && q.size() < 2;
    drn = q.size() > 0 && ordy;
    if (drn) begin
      if (q[0].w && q[0].a != '0) cnt++;
      void'(q.pop_front());
    end
    if (fl) q.delete();
    else if (acc) q.push_back('{a: ia, d: id, w: iw});
    @(posedge clk);
  endtask
  task automatic do_reset(input logic iv);
    @(negedge clk);
    reset = 1'b1; in_valid = iv; in_addr = 5'd9; in_data = 32'h99; in_we = 1'b1;
    out_ready = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    q.delete();
    cnt = '0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_retire_cnt", retire_cnt, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_addr", out_addr, '0);
    chk("rst_out_data", out_data, '0);
  endtask
  initial begin
    do_reset(1'b0);
    step(0, 0, 0, 0, 1, 0);
    // single write, 1-cycle latency, counter follows
    step(1, 5, 32'h0000000F, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("cnt_after_first", retire_cnt, 4'd1);
    // backpressure: fill both entries, a third push is refused, then drain in order
    step(1, 3, 32'hA, 1, 0, 0);
    step(1, 4, 32'hB, 1, 0, 0);
    step(1, 9, 32'hC, 1, 0, 0);
    step(1, 10, 32'hD, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // x0 write never strobes
    step(1, 0, 32'hDEADBEEF, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // non-writing entry
    step(1, 6, 32'h66, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // flush in FULL with a live input
    step(1, 11, 32'h111, 1, 0, 0);
    step(1, 12, 32'h222, 1, 0, 0);
    step(1, 13, 32'h333, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 14, 32'h444, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // flush with a concurrent drain still retires the drained entry
    step(1, 15, 32'h555, 1, 0, 0);
    step(1, 16, 32'h666, 1, 1, 1);
    step(0, 0, 0, 0, 1, 0);
`ifdef WB_FWD_EN
    step(1, 7, 32'h11, 1, 0, 0);
    step(1, 7, 32'h22, 1, 0, 0);
    fwd_rs1 = 7; fwd_rs2 = 0;
    step(0, 0, 0, 0, 0, 0);
    chk("fwd_skid_wins", fwd_data1, 32'h22);
    fwd_rs2 = 7;
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
`endif
    // random traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    // counter wrap: 16 writing retirements from zero
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) step(1, AW'(i % 31 + 1), DW'(i), 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("cnt_wrap", retire_cnt, 4'd0);
    // reset while FULL discards both entries without retiring them
    step(1, 20, 32'h20, 1, 1, 0);
    step(1, 21, 32'h21, 1, 0, 0);
    step(1, 22, 32'h22, 1, 0, 0);
    do_reset(1'b1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 23, 32'h23, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of writeback data.
REQ-002 Parameter ADDR_W, default 5, width of destination register index.
REQ-003 Parameter CNT_W, default 16, width of retire counter.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream (MEM/WB) entry present.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 in_addr  input  ADDR_W  destination register index.
REQ-009 in_data  input  DATA_W  writeback data.
REQ-010 in_we  input  1  entry requests a register write.
REQ-011 flush  input  1  discard all held entries and the current input.
REQ-012 out_valid  output  1  output entry present.
REQ-013 out_ready  input  1  register file consumes the output entry this cycle.
REQ-014 out_addr / out_data  output  ADDR_W / DATA_W  held entry fields.
REQ-015 out_we  output  1  qualified write strobe.
REQ-016 retire_cnt  output  CNT_W  count of retired writing entries.
REQ-017 fwd_rs1, fwd_rs2  input  ADDR_W  forwarding lookup indices (WB_FWD_EN only).
REQ-018 fwd_hit1/2  output 1, fwd_data1/2  output DATA_W  forwarding results (WB_FWD_EN only).

Function
REQ-019 Block SHALL be a two-entry skid buffer: output register (OUT) plus skid register (SKID); states EMPTY, ONE, FULL.
REQ-020 in_ready SHALL equal !SKID.valid (combinational from state only, never from out_ready).
REQ-021 Accept = in_valid && in_ready; drain = out_valid && out_ready.
REQ-022 EMPTY: accept -> ONE, OUT loaded; latency in->out exactly 1 cycle.
REQ-023 ONE: accept&&drain -> ONE, OUT reloaded with input; accept only -> FULL, input to SKID; drain only -> EMPTY.
REQ-024 FULL: drain -> ONE, SKID moved to OUT; no accept possible; no drain -> hold all fields.
REQ-025 Entries SHALL leave in arrival order; no entry dropped or duplicated absent flush/reset.
REQ-026 out_we SHALL equal out_valid && OUT.we && (OUT.addr != 0); x0 writes never strobe.
REQ-027 retire_cnt SHALL increment by 1 on each drain with out_we=1; wraps from 2^CNT_W-1 to 0.
REQ-028 flush SHALL clear OUT.valid and SKID.valid next cycle; input presented in the flush cycle SHALL be discarded; retire_cnt SHALL still count a drain occurring in the flush cycle.
REQ-029 out_addr/out_data SHALL hold their last values while out_valid=0 (no requirement on value).

Reset
REQ-030 reset SHALL take priority over flush and all traffic.
REQ-031 After reset: state EMPTY, out_valid=0, out_we=0, in_ready=1, retire_cnt=0, out_addr=0, out_data=0, SKID cleared, fwd_hit1/2=0.
REQ-032 Reset asserted mid-operation SHALL discard OUT and SKID without retiring them.

Configuration
REQ-033 Macro WB_FWD_EN defined: fwd_hitN=1 when fwd_rsN!=0 and a valid entry with we=1 matches; SKID (younger) SHALL win over OUT; fwd_dataN = matching entry data; fully combinational, 0-cycle.
REQ-034 Macro WB_FWD_EN undefined: fwd_* ports SHALL not exist; no forwarding logic synthesised.

Verification
REQ-035 Reset, then in_valid=1 addr=5 data=0x0000000F we=1, out_ready=1 -> next cycle out_valid=1, out_we=1, out_data=0x0000000F; following cycle retire_cnt=1.
REQ-036 out_ready=0, push A(addr=3) then B(addr=4) -> in_ready=0 after B; raise out_ready -> A then B on consecutive cycles, in_ready returns 1.
REQ-037 Push addr=0 we=1 data=0xDEADBEEF -> out_valid=1, out_we=0, retire_cnt unchanged.
REQ-038 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-039 WB_FWD_EN: OUT addr=7 data=0x11, SKID addr=7 data=0x22, fwd_rs1=7 -> fwd_hit1=1, fwd_data1=0x22; fwd_rs2=0 -> fwd_hit2=0.
REQ-040 CNT_W=4, retire 16 writing entries -> retire_cnt wraps to 0; reset during FULL -> out_valid=0, retire_cnt=0 next cycle.
